// File: rtl/alu_arbiter_pkg.sv
// Shared ALU opcode constants and port identifiers for the arbitrated ALU.
package alu_arbiter_pkg;

    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b110;
    localparam logic [2:0] ALU_AND      = 3'b000;
    localparam logic [2:0] ALU_OR       = 3'b001;
    localparam logic [2:0] ALU_SLT      = 3'b111;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    function automatic logic op_legal(input logic [2:0] ctl);
        case (ctl)
            ALU_ADD, ALU_SUBTRACT, ALU_AND, ALU_OR, ALU_SLT: return 1'b1;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU shared between the two arbitrated ports.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [2:0] Ctl,
    input  logic [7:0] SrcA,
    input  logic [7:0] SrcB,
    output logic [7:0] Result
);

    always_comb begin
        Result = '0;
        case (Ctl)
            ALU_ADD:      Result = SrcA + SrcB;
            ALU_SUBTRACT: Result = SrcA - SrcB;
            ALU_AND:      Result = SrcA & SrcB;
            ALU_OR:       Result = SrcA | SrcB;
            ALU_SLT:      Result = (SrcA < SrcB) ? 8'h01 : 8'h00;
            default:      Result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of one shared ALU; one operation
// per two cycles, with a one-cycle grant and a one-cycle result strobe.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter bit DEFAULT_PRI = 1'b0
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       ReqA,
    input  logic [2:0] CtlA,
    input  logic [7:0] SrcAA,
    input  logic [7:0] SrcBA,
    output logic       GntA,
    output logic       RespValidA,
    output logic [7:0] ResultA,
    output logic       ZeroA,
    input  logic       ReqB,
    input  logic [2:0] CtlB,
    input  logic [7:0] SrcAB,
    input  logic [7:0] SrcBB,
    output logic       GntB,
    output logic       RespValidB,
    output logic [7:0] ResultB,
    output logic       ZeroB,
    output logic       Busy
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t     state;
    port_t      owner;
    port_t      last_gnt;
    port_t      winner;
    logic       any_req;
    logic [2:0] ctl_q;
    logic [7:0] srca_q;
    logic [7:0] srcb_q;
    logic [7:0] alu_result;
    logic [7:0] result_next;

    alu_arbiter_alu u_alu (
        .Ctl    (ctl_q),
        .SrcA   (srca_q),
        .SrcB   (srcb_q),
        .Result (alu_result)
    );

    // On a tie the port opposite the last grant wins.
    always_comb begin
        any_req = ReqA | ReqB;
        winner  = PORT_A;
        if (ReqA && ReqB)
            winner = (last_gnt == PORT_A) ? PORT_B : PORT_A;
        else if (ReqB)
            winner = PORT_B;
    end

    // Illegal opcodes complete with a forced zero result whatever the ALU produces.
    always_comb begin
        result_next = op_legal(ctl_q) ? alu_result : '0;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            owner      <= PORT_A;
            last_gnt   <= DEFAULT_PRI ? PORT_A : PORT_B;
            ctl_q      <= '0;
            srca_q     <= '0;
            srcb_q     <= '0;
            GntA       <= 1'b0;
            GntB       <= 1'b0;
            RespValidA <= 1'b0;
            RespValidB <= 1'b0;
            ResultA    <= '0;
            ResultB    <= '0;
            ZeroA      <= 1'b0;
            ZeroB      <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            GntA       <= 1'b0;
            GntB       <= 1'b0;
            RespValidA <= 1'b0;
            RespValidB <= 1'b0;
            Busy       <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (any_req) begin
                        state    <= EXEC;
                        owner    <= winner;
                        last_gnt <= winner;
                        Busy     <= 1'b1;
                        if (winner == PORT_B) begin
                            ctl_q  <= CtlB;
                            srca_q <= SrcAB;
                            srcb_q <= SrcBB;
                            GntB   <= 1'b1;
                        end else begin
                            ctl_q  <= CtlA;
                            srca_q <= SrcAA;
                            srcb_q <= SrcBA;
                            GntA   <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                EXEC: begin
                    state <= DONE;
                    if (owner == PORT_B) begin
                        ResultB    <= result_next;
                        ZeroB      <= (result_next == 8'h00);
                        RespValidB <= 1'b1;
                    end else begin
                        ResultA    <= result_next;
                        ZeroA      <= (result_next == 8'h00);
                        RespValidA <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with hand-computed results.
module tb_alu_arbiter;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       ReqA = 1'b0;
    logic [2:0] CtlA = 3'b000;
    logic [7:0] SrcAA = 8'h00;
    logic [7:0] SrcBA = 8'h00;
    logic       GntA;
    logic       RespValidA;
    logic [7:0] ResultA;
    logic       ZeroA;
    logic       ReqB = 1'b0;
    logic [2:0] CtlB = 3'b000;
    logic [7:0] SrcAB = 8'h00;
    logic [7:0] SrcBB = 8'h00;
    logic       GntB;
    logic       RespValidB;
    logic [7:0] ResultB;
    logic       ZeroB;
    logic       Busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.DEFAULT_PRI(1'b0)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .ReqA       (ReqA),
        .CtlA       (CtlA),
        .SrcAA      (SrcAA),
        .SrcBA      (SrcBA),
        .GntA       (GntA),
        .RespValidA (RespValidA),
        .ResultA    (ResultA),
        .ZeroA      (ZeroA),
        .ReqB       (ReqB),
        .CtlB       (CtlB),
        .SrcAB      (SrcAB),
        .SrcBB      (SrcBB),
        .GntB       (GntB),
        .RespValidB (RespValidB),
        .ResultB    (ResultB),
        .ZeroB      (ZeroB),
        .Busy       (Busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_op(input bit port, input logic [2:0] ctl, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er, input logic ez,
                          input string tag);
        if (port) begin
            ReqB = 1'b1; CtlB = ctl; SrcAB = a; SrcBB = b;
        end else begin
            ReqA = 1'b1; CtlA = ctl; SrcAA = a; SrcBA = b;
        end
        tick;
        chk({tag, ".gnt"},   port ? GntB : GntA, 8'd1);
        chk({tag, ".ogn"},   port ? GntA : GntB, 8'd0);
        chk({tag, ".busy"},  Busy, 8'd1);
        ReqA = 1'b0;
        ReqB = 1'b0;
        tick;
        chk({tag, ".rv"},    port ? RespValidB : RespValidA, 8'd1);
        chk({tag, ".orv"},   port ? RespValidA : RespValidB, 8'd0);
        chk({tag, ".res"},   port ? ResultB : ResultA, er);
        chk({tag, ".zero"},  port ? ZeroB : ZeroA, {7'd0, ez});
        tick;
        chk({tag, ".rvoff"}, port ? RespValidB : RespValidA, 8'd0);
        chk({tag, ".hold"},  port ? ResultB : ResultA, er);
    endtask

    bit         ega  [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
    bit         egb  [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    logic [7:0] expa [2] = '{8'h12, 8'hFF};
    logic [7:0] expb [2] = '{8'h30, 8'h42};

    initial begin
        // Reset held; a pending request must not be granted yet
        ReqA = 1'b1; CtlA = 3'b010; SrcAA = 8'h05; SrcBA = 8'h03;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.gnta", GntA, 8'd0);
        chk("rst.gntb", GntB, 8'd0);
        chk("rst.rva", RespValidA, 8'd0);
        chk("rst.rvb", RespValidB, 8'd0);
        chk("rst.busy", Busy, 8'd0);
        chk("rst.resa", ResultA, 8'h00);
        chk("rst.resb", ResultB, 8'h00);
        chk("rst.zeroa", ZeroA, 8'd0);
        chk("rst.zerob", ZeroB, 8'd0);
        @(negedge CLK);
        Reset = 1'b0;

        // Single ADD on port A, sampled on first edge after reset
        tick;
        chk("add.gnta", GntA, 8'd1);
        chk("add.gntb", GntB, 8'd0);
        chk("add.busy", Busy, 8'd1);
        ReqA = 1'b0;
        tick;
        chk("add.rva", RespValidA, 8'd1);
        chk("add.resa", ResultA, 8'h08);
        chk("add.zeroa", ZeroA, 8'd0);
        chk("add.gntoff", GntA, 8'd0);
        chk("add.busyoff", Busy, 8'd0);
        chk("add.rvb", RespValidB, 8'd0);
        chk("add.resb", ResultB, 8'h00);
        tick;
        chk("add.rvoff", RespValidA, 8'd0);
        chk("add.hold", ResultA, 8'h08);

        // Reset restores A priority for the tie
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        ReqA = 1'b1; CtlA = 3'b110; SrcAA = 8'h10; SrcBA = 8'h10;
        ReqB = 1'b1; CtlB = 3'b001; SrcAB = 8'hF0; SrcBB = 8'h0F;
        tick;
        chk("tie.gnta", GntA, 8'd1);
        chk("tie.gntb", GntB, 8'd0);
        ReqA = 1'b0;
        tick;
        chk("tie.rva", RespValidA, 8'd1);
        chk("tie.resa", ResultA, 8'h00);
        chk("tie.zeroa", ZeroA, 8'd1);
        chk("tie.nogntb", GntB, 8'd0);
        chk("tie.resb", ResultB, 8'h00);
        tick;
        chk("tie.gntb2", GntB, 8'd1);
        chk("tie.rvaoff", RespValidA, 8'd0);
        ReqB = 1'b0;
        tick;
        chk("tie.rvb", RespValidB, 8'd1);
        chk("tie.resb2", ResultB, 8'hFF);
        chk("tie.zerob", ZeroB, 8'd0);
        chk("tie.holda", ResultA, 8'h00);
        tick;

        // Both ports requesting continuously: A,B,A,B every two cycles
        ReqA = 1'b1; CtlA = 3'b010; SrcAA = 8'h11; SrcBA = 8'h01;
        ReqB = 1'b1; CtlB = 3'b000; SrcAB = 8'hF3; SrcBB = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk($sformatf("alt%0d.gnta", i), GntA, {7'd0, ega[i]});
            chk($sformatf("alt%0d.gntb", i), GntB, {7'd0, egb[i]});
            if (i % 4 == 1) begin
                chk($sformatf("alt%0d.rva", i), RespValidA, 8'd1);
                chk($sformatf("alt%0d.resa", i), ResultA, expa[i / 4]);
            end
            if (i % 4 == 3) begin
                chk($sformatf("alt%0d.rvb", i), RespValidB, 8'd1);
                chk($sformatf("alt%0d.resb", i), ResultB, expb[i / 4]);
            end
            if (i == 0) begin
                CtlA = 3'b110; SrcAA = 8'h20; SrcBA = 8'h21;
            end
            if (i == 2) begin
                CtlB = 3'b001; SrcAB = 8'h40; SrcBB = 8'h02;
            end
        end
        ReqA = 1'b0;
        ReqB = 1'b0;
        tick;
        chk("alt.end.gnta", GntA, 8'd0);
        chk("alt.end.gntb", GntB, 8'd0);

        // Boundary operations
        run_op(1'b0, 3'b010, 8'hFF, 8'h02, 8'h01, 1'b0, "addwrap");
        run_op(1'b0, 3'b111, 8'h02, 8'h07, 8'h01, 1'b0, "slt_lt");
        run_op(1'b1, 3'b111, 8'hFF, 8'h01, 8'h00, 1'b1, "slt_ge");
        run_op(1'b0, 3'b100, 8'h05, 8'h03, 8'h00, 1'b1, "illegal_a");
        run_op(1'b1, 3'b101, 8'h05, 8'h03, 8'h00, 1'b1, "illegal_b");
        run_op(1'b0, 3'b010, 8'h40, 8'h40, 8'h80, 1'b0, "add80");

        // Reset in the middle of an EXEC cycle on port A
        ReqA = 1'b1; CtlA = 3'b010; SrcAA = 8'h05; SrcBA = 8'h03;
        tick;
        chk("abort.gnta", GntA, 8'd1);
        ReqA = 1'b0;
        #2;
        Reset = 1'b1;
        #1;
        chk("abort.gnta0", GntA, 8'd0);
        chk("abort.busy0", Busy, 8'd0);
        chk("abort.resa0", ResultA, 8'h00);
        chk("abort.zerob0", ZeroB, 8'd0);
        chk("abort.rva0", RespValidA, 8'd0);
        @(negedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        tick;
        chk("abort.norv1", RespValidA, 8'd0);
        chk("abort.nogn1", GntA, 8'd0);
        chk("abort.resa1", ResultA, 8'h00);
        tick;
        chk("abort.norv2", RespValidA, 8'd0);
        ReqA = 1'b1; CtlA = 3'b000; SrcAA = 8'hAA; SrcBA = 8'h0F;
        ReqB = 1'b1; CtlB = 3'b001; SrcAB = 8'h01; SrcBB = 8'h02;
        tick;
        chk("abort.tie.gnta", GntA, 8'd1);
        chk("abort.tie.gntb", GntB, 8'd0);
        ReqA = 1'b0;
        tick;
        chk("abort.tie.rva", RespValidA, 8'd1);
        chk("abort.tie.resa", ResultA, 8'h0A);
        tick;
        chk("abort.tie.gntb2", GntB, 8'd1);
        ReqB = 1'b0;
        tick;
        chk("abort.tie.resb", ResultB, 8'h03);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DEFAULT_PRI, 0, port favoured first after reset (0 = A, 1 = B).
REQ-002 CLK  in  1  sole clock, all state on rising edge.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 ReqA  in  1  port A request; held with CtlA/SrcAA/SrcBA stable until GntA seen.
REQ-005 CtlA  in  3  ALU opcode, port A.
REQ-006 SrcAA  in  8  operand A, port A.
REQ-007 SrcBA  in  8  operand B, port A.
REQ-008 GntA  out  1  one-cycle grant, port A.
REQ-009 RespValidA  out  1  one-cycle result strobe, port A.
REQ-010 ResultA  out  8  result, port A; holds until next port-A response.
REQ-011 ZeroA  out  1  result-is-zero flag, port A; holds with ResultA.
REQ-012 ReqB, CtlB, SrcAB, SrcBB, GntB, RespValidB, ResultB, ZeroB  same directions/widths/meanings for port B.
REQ-013 Busy  out  1  high while an operation is in EXEC.

Function
REQ-014 FSM states IDLE, EXEC, DONE; one shared ALU instance evaluates only latched operands.
REQ-015 IDLE/DONE: at a clock edge with any Req high, latch winner's Ctl/SrcA/SrcB and owner, go EXEC; else go IDLE.
REQ-016 EXEC: Gnt of owner high for exactly this cycle; Busy high; next edge registers Result/Zero to owner's port, go DONE.
REQ-017 DONE: owner's RespValid high for exactly this cycle; request sampling identical to IDLE.
REQ-018 Latency: Req sampled at edge k -> Gnt during cycle k..k+1 -> RespValid during cycle k+1..k+2; max throughput one op per 2 cycles.
REQ-019 Arbitration: single requester wins; both requesting -> port opposite last grant wins; last-grant pointer updates on every grant.
REQ-020 Requester drops Req after seeing Gnt; Req held in EXEC cycle shall not be resampled; Req withdrawn before grant has no effect.
REQ-021 Opcodes 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT; 8-bit modulo arithmetic, SLT unsigned, result 8'h01/8'h00.
REQ-022 Illegal opcodes 011/100/101: granted and completed normally with Result 8'h00, Zero 1, independent of ALU output.
REQ-023 Zero shall be derived from the registered 8-bit result (==0), not from the ALU Zero output.
REQ-024 Gnt and RespValid of both ports never high simultaneously; non-owner outputs unchanged during an operation.

Reset
REQ-025 Reset asynchronously forces state IDLE, pointer so DEFAULT_PRI port wins first tie, all Gnt/RespValid/Busy 0, Result 8'h00, Zero 0.
REQ-026 Reset during EXEC or DONE aborts the operation; no RespValid issued for it after release.
REQ-027 First request sampled on first rising edge after Reset deasserts.

Structure
REQ-028 Opcode macros (ALU_ADD, ALU_SUBTRACT, ALU_AND, ALU_OR, ALU_SLT) live in a shared defines include used by ALU and alu_arbiter.
REQ-029 State encodings are local to alu_arbiter.
REQ-030 Exactly one sub-module: the existing ALU, instantiated once.

Verification
REQ-031 Reset, ReqA ADD 8'h05+8'h03 -> GntA 1 cycle, RespValidA next cycle, ResultA 8'h08, ZeroA 0; port B outputs silent.
REQ-032 From reset (DEFAULT_PRI 0) ReqA SUB 8'h10-8'h10 and ReqB OR 8'hF0|8'h0F same edge -> A first: 8'h00 Zero 1; then B: 8'hFF Zero 0.
REQ-033 Both Req held continuously with fresh ops -> grants alternate A,B,A,B, one per 2 cycles, no double grant.
REQ-034 Boundaries: ADD 8'hFF+8'h02 -> 8'h01; SLT 8'h02,8'h07 -> 8'h01; SLT 8'hFF,8'h01 -> 8'h00 Zero 1; CtlA 3'b100 -> 8'h00 Zero 1.
REQ-035 Reset asserted mid-EXEC -> outputs zeroed immediately, no RespValid after release, next tie goes to DEFAULT_PRI port.
